// File: rtl/saradc_sar_ctrl.sv
// ---------------------------------------------------------------------------
// saradc_sar_ctrl
// Successive-approximation controller for the SAR ADC macro. It runs the
// sampling switch, steps the capacitive-DAC trial bits from MSB to LSB,
// strobes the comparator once per bit and collects the decisions into an
// NBITS code.
//
// Parameters
//   NBITS    conversion resolution in bits (>= 1)
//   NSAMPLE  sampling-phase length in clock cycles (>= 1)
//   TIMEOUT  WAIT cycles before a forced "keep" decision (>= 1, timeout build)
//
// Ports
//   clk_i          conversion clock, rising edge
//   rst_ni         asynchronous active-low reset
//   start_i        conversion request, sampled only while idle
//   busy_o         high whenever a conversion is in progress
//   sample_o       closes the sampling switch
//   dac_p_o        DAC trial-bit controls, MSB = dac_p_o[NBITS-1]
//   cmp_en_o       one-cycle comparator strobe per bit
//   cmp_rdy_i      comparator decision valid
//   cmp_out_i      1 = input >= DAC level, keep the trial bit
//   dout_o         last converted code, held until the next done
//   done_o         one-cycle pulse, dout_o valid in the same cycle
//   timeout_err_o  sticky comparator-timeout flag
//
// Build option
//   SARADC_CMP_TIMEOUT_EN  when defined, a stalled comparator is overridden
//                          after TIMEOUT WAIT cycles and timeout_err_o is set;
//                          when undefined, WAIT holds forever and
//                          timeout_err_o is tied low.
// ---------------------------------------------------------------------------
module saradc_sar_ctrl #(
   parameter int NBITS   = 8,
   parameter int NSAMPLE = 4,
   parameter int TIMEOUT = 15
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   output logic             busy_o,
   output logic             sample_o,
   output logic [NBITS-1:0] dac_p_o,
   output logic             cmp_en_o,
   input  logic             cmp_rdy_i,
   input  logic             cmp_out_i,
   output logic [NBITS-1:0] dout_o,
   output logic             done_o,
   output logic             timeout_err_o
);

   localparam int SCW = (NSAMPLE > 1) ? $clog2(NSAMPLE) : 1;
   localparam int IW  = (NBITS > 1) ? $clog2(NBITS) : 1;

   // Reject degenerate configurations at elaboration time.
   if (NBITS < 1 || NSAMPLE < 1 || TIMEOUT < 1) begin : gBadParams
      $error("saradc_sar_ctrl: NBITS, NSAMPLE and TIMEOUT must all be >= 1");
   end

   typedef enum logic [2:0] {
      IDLE,
      SAMP,
      STROBE,
      WAIT,
      FIN
   } state_e;

   state_e           state_q, state_d;
   logic [SCW-1:0]   sampCnt_q, sampCnt_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [NBITS-1:0] dac_q, dac_d;
   logic [NBITS-1:0] dout_q, dout_d;
   logic             busy_q, busy_d;
   logic             sample_q, sample_d;
   logic             cmpEn_q, cmpEn_d;
   logic             done_q, done_d;
   logic             decide;
   logic             keep;

`ifdef SARADC_CMP_TIMEOUT_EN
   localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [TCW-1:0]   waitCnt_q, waitCnt_d;
   logic             err_q, err_d;
`endif

   // State and datapath registers. Every output is taken straight from a
   // flop, so nothing on the input side reaches an output combinationally.
   // Reset discards any conversion in flight and clears all outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         sampCnt_q <= '0;
         idx_q     <= '0;
         dac_q     <= '0;
         dout_q    <= '0;
         busy_q    <= 1'b0;
         sample_q  <= 1'b0;
         cmpEn_q   <= 1'b0;
         done_q    <= 1'b0;
`ifdef SARADC_CMP_TIMEOUT_EN
         waitCnt_q <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         sampCnt_q <= sampCnt_d;
         idx_q     <= idx_d;
         dac_q     <= dac_d;
         dout_q    <= dout_d;
         busy_q    <= busy_d;
         sample_q  <= sample_d;
         cmpEn_q   <= cmpEn_d;
         done_q    <= done_d;
`ifdef SARADC_CMP_TIMEOUT_EN
         waitCnt_q <= waitCnt_d;
         err_q     <= err_d;
`endif
      end
   end

   // Next-state and datapath logic. The per-state flag outputs are derived
   // from the next state so that they line up with the state register after
   // the edge. In WAIT a decision is taken when the comparator reports ready
   // (or, in the timeout build, when the WAIT counter runs out, in which case
   // the trial bit is kept). The trial bit is dropped on a "below" decision;
   // then either the next lower bit is tried or, after the LSB, the finished
   // code is copied to dout.
   always_comb begin
      state_d   = state_q;
      sampCnt_d = sampCnt_q;
      idx_d     = idx_q;
      dac_d     = dac_q;
      dout_d    = dout_q;
      decide    = 1'b0;
      keep      = cmp_out_i;
`ifdef SARADC_CMP_TIMEOUT_EN
      waitCnt_d = waitCnt_q;
      err_d     = err_q;
`endif

      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d   = SAMP;
               sampCnt_d = SCW'(NSAMPLE - 1);
               dac_d     = '0;
`ifdef SARADC_CMP_TIMEOUT_EN
               err_d     = 1'b0;
`endif
            end
         end
         SAMP: begin
            if (sampCnt_q == '0) begin
               state_d            = STROBE;
               idx_d              = IW'(NBITS - 1);
               dac_d              = '0;
               dac_d[NBITS-1]     = 1'b1;
            end else begin
               sampCnt_d = sampCnt_q - SCW'(1);
            end
         end
         STROBE: begin
            state_d   = WAIT;
`ifdef SARADC_CMP_TIMEOUT_EN
            waitCnt_d = TCW'(TIMEOUT - 1);
`endif
         end
         WAIT: begin
            if (cmp_rdy_i) begin
               decide = 1'b1;
            end
`ifdef SARADC_CMP_TIMEOUT_EN
            else if (waitCnt_q == '0) begin
               decide = 1'b1;
               keep   = 1'b1;
               err_d  = 1'b1;
            end else begin
               waitCnt_d = waitCnt_q - TCW'(1);
            end
`endif
            if (decide) begin
               if (!keep) begin
                  dac_d[idx_q] = 1'b0;
               end
               if (idx_q == '0) begin
                  state_d = FIN;
                  dout_d  = dac_d;
               end else begin
                  dac_d[idx_q - IW'(1)] = 1'b1;
                  idx_d                 = idx_q - IW'(1);
                  state_d               = STROBE;
               end
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d   = (state_d != IDLE);
      sample_d = (state_d == SAMP);
      cmpEn_d  = (state_d == STROBE);
      done_d   = (state_d == FIN);
   end

   assign busy_o   = busy_q;
   assign sample_o = sample_q;
   assign dac_p_o  = dac_q;
   assign cmp_en_o = cmpEn_q;
   assign dout_o   = dout_q;
   assign done_o   = done_q;

`ifdef SARADC_CMP_TIMEOUT_EN
   assign timeout_err_o = err_q;
`else
   assign timeout_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_saradc_sar_ctrl.sv
// ---------------------------------------------------------------------------
// tb_saradc_sar_ctrl
// Self-checking bench for saradc_sar_ctrl (NBITS=8, NSAMPLE=4, TIMEOUT=15).
// An ideal comparator answers each strobe after a chosen delay with
// CMP_OUT = (VIN >= DAC_P) and raises spurious CMP_RDY whenever no answer is
// owed. A conversion-level model builds the expected timeline (sample
// window, strobe cycles, DAC trial values, done cycle, result code) from the
// chosen delays when a START is accepted, and every cycle the outputs are
// compared with it.
// ---------------------------------------------------------------------------
module tb_saradc_sar_ctrl;

   localparam int NB    = 8;
   localparam int NS    = 4;
   localparam int TO    = 15;
   localparam int NEVER = 1000;
`ifdef SARADC_CMP_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk    = 1'b0;
   logic          rstN   = 1'b0;
   logic          start  = 1'b0;
   logic          cmpRdy = 1'b0;
   logic          cmpOut = 1'b0;
   logic          busy, sample, cmpEn, done, timeoutErr;
   logic [NB-1:0] dacP, dout;

   saradc_sar_ctrl #(.NBITS(NB), .NSAMPLE(NS), .TIMEOUT(TO)) dut (
      .clk_i        (clk),
      .rst_ni       (rstN),
      .start_i      (start),
      .busy_o       (busy),
      .sample_o     (sample),
      .dac_p_o      (dacP),
      .cmp_en_o     (cmpEn),
      .cmp_rdy_i    (cmpRdy),
      .cmp_out_i    (cmpOut),
      .dout_o       (dout),
      .done_o       (done),
      .timeout_err_o(timeoutErr)
   );

   always #5 clk = ~clk;

   int checkCount = 0;
   int passCount  = 0;
   int cycle      = 0;

   // Conversion model: ofs counts cycles since the edge that accepted START
   // (-1 while idle).
   int            ofs = -1;
   int            strobeAt[NB];
   logic [NB-1:0] trialAt[NB];
   int            kPlan[NB];
   int            doneAt = 0;
   int            errAt  = -1;
   logic [NB-1:0] vin    = '0;
   logic [NB-1:0] result = '0;
   logic [NB-1:0] lastDout = '0;
   logic [NB-1:0] lastDac  = '0;
   bit            errSticky = 1'b0;
   int            vinQ[$];
   int            kMode = 0;
   bit            startLevel = 1'b0;

   // Comparator state.
   bit waiting = 1'b0;
   int pending = 0;
   int bitIdx  = 0;

   // Observations of the DUT for the literal checks.
   int            doneSeenOfs = -1;
   int            sampleSeen  = 0;
   int            cmpEnSeen   = 0;
   int            doneCycle   = -1;
   int            sampCycle   = -1;
   logic [NB-1:0] doneDout    = '0;

   task automatic checkValue(input string name, input int actual, input int expected);
      checkCount++;
      if (actual == expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
   endtask

   // Build the expected timeline of a newly accepted conversion.
   function automatic void loadConversion();
      int            o;
      int            keff;
      bit            forced;
      logic [NB-1:0] code;
      logic [NB-1:0] trial;
      logic [NB-1:0] one;
      vin = (vinQ.size() > 0) ? NB'(vinQ.pop_front()) : NB'($urandom);
      for (int i = 0; i < NB; i++) begin
         case (kMode)
            0:       kPlan[i] = int'($urandom_range(1, 4));
            1:       kPlan[i] = 1;
            2:       kPlan[i] = (i == 0) ? 6 : 1;
            default: kPlan[i] = NEVER;
         endcase
      end
      o     = NS;
      code  = '0;
      one   = NB'(1);
      errAt = -1;
      for (int i = 0; i < NB; i++) begin
         trial       = code | (one << (NB - 1 - i));
         strobeAt[i] = o;
         trialAt[i]  = trial;
         forced      = TO_EN && (kPlan[i] > TO);
         keff        = forced ? TO : kPlan[i];
         if (forced) begin
            if (errAt < 0) errAt = o + keff + 1;
            code = trial;
         end else if (vin >= trial) begin
            code = trial;
         end
         o += 1 + keff;
      end
      doneAt      = o;
      result      = code;
      sampleSeen  = 0;
      cmpEnSeen   = 0;
      doneSeenOfs = -1;
      bitIdx      = 0;
   endfunction

   // Compare all outputs with the model for the current cycle.
   task automatic checkOutput();
      logic          expBusy, expSample, expCmpEn, expDone, expErr;
      logic [NB-1:0] expDac, expDout;
      expBusy   = 1'b0;
      expSample = 1'b0;
      expCmpEn  = 1'b0;
      expDone   = 1'b0;
      expDac    = lastDac;
      expDout   = lastDout;
      expErr    = errSticky;
      if (ofs >= 0) begin
         expBusy   = 1'b1;
         expSample = (ofs < NS);
         expDac    = '0;
         expErr    = (errAt >= 0) && (ofs >= errAt);
         for (int i = 0; i < NB; i++) begin
            if (ofs >= strobeAt[i] && ofs < doneAt) expDac = trialAt[i];
            if (ofs == strobeAt[i]) expCmpEn = 1'b1;
         end
         if (ofs == doneAt) begin
            expDone = 1'b1;
            expDac  = result;
            expDout = result;
         end
      end
      checkValue("busy", busy, expBusy);
      checkValue("sample", sample, expSample);
      checkValue("cmp_en", cmpEn, expCmpEn);
      checkValue("done", done, expDone);
      checkValue("dac_p", dacP, expDac);
      checkValue("dout", dout, expDout);
      checkValue("timeout_err", timeoutErr, expErr);
      if (ofs >= 0 && sample) sampleSeen++;
      if (ofs == 0 && sample) sampCycle = cycle;
      if (ofs >= 0 && cmpEn) cmpEnSeen++;
      if (done) begin
         doneSeenOfs = ofs;
         doneCycle   = cycle;
         doneDout    = dout;
      end
   endtask

   // Drive START and the comparator for the current cycle.
   task automatic applyStimulus();
      start = startLevel;
      if (waiting) begin
         pending--;
         if (pending == 0) begin
            cmpRdy  = 1'b1;
            cmpOut  = (vin >= dacP);
            waiting = 1'b0;
         end else begin
            cmpRdy = 1'b0;
            cmpOut = 1'($urandom);
         end
      end else begin
         cmpRdy = 1'($urandom);
         cmpOut = 1'($urandom);
      end
      if (cmpEn && rstN) begin
         waiting = 1'b1;
         pending = (bitIdx < NB) ? kPlan[bitIdx] : NEVER;
         bitIdx++;
      end
   endtask

   task automatic advanceModel();
      if (ofs < 0) begin
         if (start && rstN) begin
            loadConversion();
            ofs = 0;
         end
      end else if (ofs == doneAt) begin
         lastDout  = result;
         lastDac   = result;
         errSticky = (errAt >= 0);
         waiting   = 1'b0;
         ofs       = -1;
      end else begin
         ofs++;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      checkOutput();
      applyStimulus();
      advanceModel();
      cycle++;
   endtask

   task automatic pulseStart();
      startLevel = 1'b1;
      tick();
      startLevel = 1'b0;
   endtask

   task automatic waitIdle(input int budget);
      for (int n = 0; n < budget && ofs >= 0; n++) tick();
      checkValue("conversion completes", (doneSeenOfs >= 0) ? 1 : 0, 1);
   endtask

   task automatic resetModel();
      ofs       = -1;
      waiting   = 1'b0;
      lastDout  = '0;
      lastDac   = '0;
      errSticky = 1'b0;
   endtask

   initial begin
      int d1;
      int c1;

      // Reset and idle state.
      tick();
      tick();
      #2 rstN = 1'b1;
      tick();

      // VIN=0xA5, one-cycle START: done 20 cycles after the start edge.
      vinQ.push_back('hA5);
      kMode = 1;
      pulseStart();
      waitIdle(100);
      checkValue("s1 model latency", doneAt, 20);
      checkValue("s1 done latency", doneSeenOfs, 20);
      checkValue("s1 dout", doneDout, 'hA5);
      checkValue("s1 sample cycles", sampleSeen, 4);
      checkValue("s1 cmp_en pulses", cmpEnSeen, 8);

      // START held high: 0x00 then 0xFF back to back.
      vinQ.push_back('h00);
      vinQ.push_back('hFF);
      startLevel = 1'b1;
      tick();
      waitIdle(100);
      d1 = int'(doneDout);
      c1 = doneCycle;
      tick();
      startLevel = 1'b0;
      waitIdle(100);
      checkValue("s2 first dout", d1, 'h00);
      checkValue("s2 second dout", doneDout, 'hFF);
      checkValue("s2 restart gap", sampCycle - c1, 2);

      // Reset during bit 5, then convert 0x3C.
      vinQ.push_back('h5A);
      kMode = 1;
      pulseStart();
      for (int n = 0; n < 50 && cmpEnSeen < 3; n++) tick();
      checkValue("s3 reached bit 5", cmpEnSeen, 3);
      #2 rstN = 1'b0;
      #1;
      resetModel();
      checkValue("s3 rst busy", busy, 0);
      checkValue("s3 rst sample", sample, 0);
      checkValue("s3 rst cmp_en", cmpEn, 0);
      checkValue("s3 rst dac_p", dacP, 0);
      checkValue("s3 rst dout", dout, 0);
      checkValue("s3 rst done", done, 0);
      tick();
      tick();
      #2 rstN = 1'b1;
      tick();
      vinQ.push_back('h3C);
      pulseStart();
      waitIdle(100);
      checkValue("s3 dout", doneDout, 'h3C);

      // MSB decision stalled 6 cycles, VIN=0x80: done at cycle 25.
      vinQ.push_back('h80);
      kMode = 2;
      pulseStart();
      waitIdle(100);
      checkValue("s4 done latency", doneSeenOfs, 25);
      checkValue("s4 dout", doneDout, 'h80);

      // Randomised codes and comparator delays, START sometimes held.
      kMode = 0;
      for (int r = 0; r < 20; r++) begin
         startLevel = 1'b1;
         tick();
         if ($urandom_range(0, 3) != 0) startLevel = 1'b0;
         waitIdle(100);
         startLevel = 1'b0;
         tick();
      end

      // Comparator never answers.
      vinQ.push_back('h12);
      kMode = 3;
      pulseStart();
`ifdef SARADC_CMP_TIMEOUT_EN
      waitIdle(300);
      checkValue("s5 done latency", doneSeenOfs, 132);
      checkValue("s5 dout", doneDout, 'hFF);
      tick();
      tick();
      checkValue("s5 err sticky", timeoutErr, 1);
      kMode = 1;
      pulseStart();
      tick();
      checkValue("s5 err cleared", timeoutErr, 0);
      waitIdle(100);
`else
      for (int n = 0; n < 300; n++) tick();
      checkValue("s6 busy held", busy, 1);
      checkValue("s6 no done", doneSeenOfs, -1);
      checkValue("s6 err low", timeoutErr, 0);
`endif

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
